dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, default 10, number of valid data-memory words; BURST_MAX, default 8, maximum consecutive locked grants while the other master waits.
REQ-002 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Ports m0_req/m1_req  in  1 each  access request; master 0 is the core, master 1 is the loader/debug port.
REQ-005 Ports m0_lock/m1_lock  in  1 each  hold the grant for a burst.
REQ-006 Ports m0_we/m1_we  in  1 each; m0_addr/m1_addr  in  8 each; m0_din/m1_din  in  16 each  access command.
REQ-007 Ports m0_gnt/m1_gnt  out  1 each  access performed this cycle.
REQ-008 Ports m0_rvalid/m1_rvalid  out  1 each; m0_rdata/m1_rdata  out  16 each  read return.
REQ-009 Ports m0_err/m1_err  out  1 each  pulse: access address is out of range.
REQ-010 Ports dm_addr  out  8; dm_din  out  16; dm_we  out  1; dm_dout  in  16  memory side; the memory reads combinationally and writes on the clock edge.

Function
REQ-011 State SHALL be {IDLE, OWN0, OWN1}, registered, plus a last-owner bit and a burst counter of width clog2(BURST_MAX+1).
REQ-012 m0_gnt SHALL equal (state==OWN0 && m0_req); m1_gnt is symmetric; at most one gnt is high in any cycle.
REQ-013 Next owner from IDLE: a single requester wins; with both requesting, the master that was not last owner wins (round-robin); the last-owner bit resets to 1, so m0 wins the first tie.
REQ-014 In OWNn, next state SHALL be:
- IDLE if no request is pending.
- OWNn if mn_req && mn_lock && (other master not requesting || burst count < BURST_MAX).
- Otherwise, round-robin per REQ-013 over the current requests.
- Handover SHALL be direct, with no dead cycle.
REQ-015 Burst counter: cleared on an ownership change or entry to IDLE; incremented on each granted cycle; saturates at BURST_MAX.
REQ-016 Masters SHALL hold req/we/addr/din stable until gnt is seen; one access completes per gnt cycle.
REQ-017 Memory-side outputs:
- dm_addr and dm_din are muxed from the owner; they are 0 in IDLE.
- dm_we = gnt && we && (addr < DEPTH) for the owning master.
REQ-018 Read latency: on a gnt cycle with we=0 and addr<DEPTH, mN_rdata SHALL capture dm_dout at that edge, and mN_rvalid SHALL be high for exactly the next cycle.
- rdata holds its value until the next read.
- Writes produce no rvalid.
REQ-019 Out-of-range access (addr >= DEPTH):
- gnt is still given.
- No write occurs and no rvalid is produced.
- mN_err pulses high for the next cycle.
REQ-020 If mN_req drops while it is owner, ownership SHALL move per REQ-014 at the same edge; no access is performed for a non-requesting owner.
REQ-021 lock without req SHALL be ignored.

Reset
REQ-022 While reset is low, the block SHALL hold the following values, applied asynchronously:
- state=IDLE, last-owner=1, burst count=0.
- all gnt/rvalid/err=0, rdata=16'h0000.
- dm_we=0, dm_addr=0, dm_din=0.
REQ-023 Reset asserted mid-burst or mid-write SHALL abort without a write after assertion; after deassertion, the first grant SHALL take one full cycle from IDLE.

Structure
REQ-024 State encodings, the DEPTH default and the master index constants SHALL live in the shared define.v include.
REQ-025 The round-robin next-owner function SHALL be one sub-module, rr_pick2, with inputs req[1:0] and last, and output owner with a valid flag; everything else stays in dm_arbiter.

Verification
REQ-026 Arbitration and read latency: m0_req=1, m0_we=0, m0_addr=1, memory holds 16'h0020 at address 1 -> m0_gnt high in the cycle after req; m0_rvalid=1 and m0_rdata=16'h0020 one cycle later.
REQ-027 Round-robin: both masters request continuously with lock=0 after reset -> grants alternate m0, m1, m0, m1; never two gnt in the same cycle.
REQ-028 Burst cap: m1 holds lock=1 while m0 requests, BURST_MAX=8 -> m1 receives exactly 8 consecutive grants, then m0 is granted on the next cycle.
REQ-029 Bounds: m0 writes 16'hBEEF to address 10 -> dm_we stays 0; m0_err pulses for one cycle; a read of address 9 returns its prior contents.
REQ-030 Reset mid-write: reset driven low during m1's granted write cycle, before the edge -> no dm_we at that edge; all outputs return to reset values; the first grant after release takes one cycle from IDLE.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Holds the FSM state encoding, default memory depth and master indices.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int DEPTH_DEF = 10;
    localparam int BURST_DEF = 8;

    localparam logic MST0 = 1'b0;
    localparam logic MST1 = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// Per-master access bundle: req/lock/we/addr/din command, gnt/rvalid/rdata/err reply.
// master modport is the requesting side, slave modport is the arbiter side.
interface dm_arbiter_if;

    logic        req;
    logic        lock;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] din;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;
    logic        err;

    modport master (
        output req, lock, we, addr, din,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, lock, we, addr, din,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the non-last owner.
// Ports: req[1:0] requests, last = previous owner, owner = winner, valid = any request.
module rr_pick2
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       owner,
    output logic       valid
);

    always_comb begin
        owner = MST0;
        unique case (1'b1)
            (req == 2'b10): owner = MST1;
            (req == 2'b11): owner = ~last;
            default:        owner = MST0;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between core (m0) and loader/debug port (m1), with lock bursts.
// Ports: clk, reset (async active-low), m0/m1 slave bundles, dm_addr/dm_din/dm_we/dm_dout.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_MAX = BURST_DEF
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  m0,
    dm_arbiter_if.slave  m1,
    output logic [7:0]   dm_addr,
    output logic [15:0]  dm_din,
    output logic         dm_we,
    input  logic [15:0]  dm_dout
);

    localparam int             CW    = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]  CMAX  = CW'(BURST_MAX);
    localparam logic [8:0]     LIMIT = 9'(DEPTH);

    state_t        r_state;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_rv0, r_rv1;
    logic          r_err0, r_err1;
    logic [15:0]   r_rd0, r_rd1;

    logic          w_gnt0, w_gnt1, w_gnt;
    logic          w_we;
    logic [7:0]    w_addr;
    logic [15:0]   w_din;
    logic          w_inr;
    logic          w_last_eff;
    logic          w_pick, w_pvld;
    logic          w_keep;
    logic [CW-1:0] w_cnt_inc, w_cnt_nxt;
    state_t        w_nxt;

    assign w_gnt0 = (r_state == OWN0) && m0.req;
    assign w_gnt1 = (r_state == OWN1) && m1.req;
    assign w_gnt  = w_gnt0 | w_gnt1;

    // Command mux follows the owner, not the grant, so IDLE drives zeros.
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        w_din  = '0;
        unique case (1'b1)
            (r_state == OWN0): begin
                w_we   = m0.we;
                w_addr = m0.addr;
                w_din  = m0.din;
            end
            (r_state == OWN1): begin
                w_we   = m1.we;
                w_addr = m1.addr;
                w_din  = m1.din;
            end
            default: ;
        endcase
    end

    assign w_inr   = {1'b0, w_addr} < LIMIT;
    assign dm_addr = w_addr;
    assign dm_din  = w_din;
    assign dm_we   = w_gnt && w_we && w_inr;

    // While owning, the current owner is the one that must yield a tie.
    always_comb begin
        w_last_eff = r_last;
        unique case (1'b1)
            (r_state == OWN0): w_last_eff = MST0;
            (r_state == OWN1): w_last_eff = MST1;
            default: ;
        endcase
    end

    rr_pick2 u_rr (
        .req   ({m1.req, m0.req}),
        .last  (w_last_eff),
        .owner (w_pick),
        .valid (w_pvld)
    );

    // Count includes this cycle's grant, so the cap allows BURST_MAX grants.
    assign w_cnt_inc = (w_gnt && (r_cnt != CMAX)) ? r_cnt + 1'b1 : r_cnt;

    always_comb begin
        w_keep = 1'b0;
        unique case (1'b1)
            (r_state == OWN0):
                w_keep = m0.req && m0.lock && (!m1.req || (w_cnt_inc < CMAX));
            (r_state == OWN1):
                w_keep = m1.req && m1.lock && (!m0.req || (w_cnt_inc < CMAX));
            default: ;
        endcase
    end

    always_comb begin
        w_nxt = IDLE;
        if (w_pvld) begin
            if (w_keep) w_nxt = r_state;
            else        w_nxt = (w_pick == MST1) ? OWN1 : OWN0;
        end
    end

    assign w_cnt_nxt = ((w_nxt == r_state) && (r_state != IDLE)) ? w_cnt_inc : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= MST1;
            r_cnt   <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_state <= w_nxt;
            r_last  <= w_last_eff;
            r_cnt   <= w_cnt_nxt;
            r_rv0   <= w_gnt0 && !m0.we && w_inr;
            r_rv1   <= w_gnt1 && !m1.we && w_inr;
            r_err0  <= w_gnt0 && !w_inr;
            r_err1  <= w_gnt1 && !w_inr;
            if (w_gnt0 && !m0.we && w_inr) r_rd0 <= dm_dout;
            if (w_gnt1 && !m1.we && w_inr) r_rd1 <= dm_dout;
        end
    end

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_rv0;
    assign m1.rvalid = r_rv1;
    assign m0.rdata  = r_rd0;
    assign m1.rdata  = r_rd1;
    assign m0.err    = r_err0;
    assign m1.err    = r_err1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: memory model, read scoreboard per master, directed scenarios.
// Covers reset, read latency, round-robin, burst cap, bounds and reset mid-write.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  dm_addr;
    logic [15:0] dm_din;
    logic        dm_we;
    logic [15:0] dm_dout;

    logic [15:0] mem [256];
    logic [15:0] shadow [256];
    bit          mem_init = 1'b0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    int n_chk = 0;
    int n_err = 0;

    dm_arbiter_if m0_if ();
    dm_arbiter_if m1_if ();

    dm_arbiter #(.DEPTH(10), .BURST_MAX(8)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_dout (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 32);
            mem_init <= 1'b1;
        end else if (dm_we) begin
            mem[dm_addr] <= dm_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit m, input logic r, input logic lk,
                         input logic w, input logic [7:0] a,
                         input logic [15:0] d);
        if (m == 1'b0) begin
            m0_if.req = r; m0_if.lock = lk; m0_if.we = w;
            m0_if.addr = a; m0_if.din = d;
        end else begin
            m1_if.req = r; m1_if.lock = lk; m1_if.we = w;
            m1_if.addr = a; m1_if.din = d;
        end
    endtask

    function automatic logic gnt_of(input bit m);
        return m ? m1_if.gnt : m0_if.gnt;
    endfunction

    function automatic logic err_of(input bit m);
        return m ? m1_if.err : m0_if.err;
    endfunction

    task automatic push_rd(input bit m, input logic [7:0] a);
        if (m) q1.push_back(shadow[a]);
        else   q0.push_back(shadow[a]);
    endtask

    // One access from master m; updates the shadow/scoreboard at issue time.
    task automatic acc(input bit m, input logic w, input logic [7:0] a,
                       input logic [15:0] d);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        drive(m, 1'b1, 1'b0, w, a, d);
        if (a < 8'd10) begin
            if (w) shadow[a] = d;
            else   push_rd(m, a);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_of(m)) begin
                check("dm_we", dm_we, w && (a < 8'd10));
                check("dm_addr", dm_addr, a);
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("gnt_wait", 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        check("err", err_of(m), a >= 8'd10);
    endtask

    always @(negedge clk) begin
        if (m0_if.rvalid) begin
            if (q0.size() == 0) check("rv0_extra", m0_if.rvalid, 1'b0);
            else                check("rd0", m0_if.rdata, q0.pop_front());
        end
        if (m1_if.rvalid) begin
            if (q1.size() == 0) check("rv1_extra", m1_if.rvalid, 1'b0);
            else                check("rd1", m1_if.rdata, q1.pop_front());
        end
        check("onehot", m0_if.gnt & m1_if.gnt, 1'b0);
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt1;
        bit seen;
        for (int i = 0; i < 256; i++) shadow[i] = 16'(i * 32);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset state, with a request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", m0_if.gnt, 1'b0);
        check("rst_rv0", m0_if.rvalid, 1'b0);
        check("rst_err0", m0_if.err, 1'b0);
        check("rst_rd0", m0_if.rdata, 16'h0000);
        check("rst_we", dm_we, 1'b0);
        check("rst_addr", dm_addr, 8'h00);
        check("rst_din", dm_din, 16'h0000);

        // Read latency: gnt one cycle after req, data one cycle later.
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000);
        q0.push_back(16'h0020);
        @(negedge clk);
        check("lat_gnt_early", m0_if.gnt, 1'b0);
        @(negedge clk);
        check("lat_gnt", m0_if.gnt, 1'b1);
        check("lat_addr", dm_addr, 8'h01);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        check("lat_rv", m0_if.rvalid, 1'b1);
        @(negedge clk);
        check("lat_rv_low", m0_if.rvalid, 1'b0);
        check("lat_hold", m0_if.rdata, 16'h0020);

        // Round-robin from a fresh reset.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            push_rd(1'b0, 8'h02);
            push_rd(1'b1, 8'h03);
        end
        @(negedge clk);
        check("rr_idle", {m1_if.gnt, m0_if.gnt}, 2'b00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_seq", {m1_if.gnt, m0_if.gnt},
                  (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(posedge clk);

        // Burst cap: m1 locks, m0 waits.
        #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 16'h0000);
        for (int i = 0; i < 8; i++) push_rd(1'b1, 8'h04);
        push_rd(1'b0, 8'h05);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
        cnt1 = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_if.gnt) begin
                seen = 1'b1;
                break;
            end
            if (m1_if.gnt) cnt1++;
        end
        check("burst_len", cnt1, 8);
        check("burst_m0", seen, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(posedge clk);

        // Bounds: out-of-range write is dropped, err is a single pulse.
        acc(1'b0, 1'b1, 8'd10, 16'hBEEF);
        @(negedge clk);
        check("err_pulse_end", m0_if.err, 1'b0);
        acc(1'b0, 1'b0, 8'd9, 16'h0000);
        acc(1'b0, 1'b1, 8'd7, 16'h1234);
        acc(1'b1, 1'b0, 8'd7, 16'h0000);
        acc(1'b1, 1'b0, 8'd200, 16'h0000);
        repeat (2) @(negedge clk);

        // Reset asserted inside m1's granted write cycle.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h06, 16'h5555);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m1_if.gnt) begin
                seen = 1'b1;
                break;
            end
        end
        check("mw_gnt", seen, 1'b1);
        check("mw_we_pre", dm_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mw_we", dm_we, 1'b0);
        check("mw_gnt1", m1_if.gnt, 1'b0);
        check("mw_addr", dm_addr, 8'h00);
        check("mw_din", dm_din, 16'h0000);
        check("mw_rd0", m0_if.rdata, 16'h0000);
        check("mw_rd1", m1_if.rdata, 16'h0000);
        check("mw_rv", {m1_if.rvalid, m0_if.rvalid}, 2'b00);
        check("mw_err", {m1_if.err, m0_if.err}, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 16'h0000);
        push_rd(1'b0, 8'h06);
        @(negedge clk);
        check("post_idle", m0_if.gnt, 1'b0);
        @(negedge clk);
        check("post_gnt", m0_if.gnt, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
